sid_voice_mixer_tdm: RTL and testbench

//  Parametrised N-voice SID output stage. It replaces the three per-voice envelope multipliers and the

---
 rtl/sid_mix_pkg.sv | 39 +++
 rtl/sid_mac_lane.sv | 38 +++
 rtl/sid_voice_mixer_tdm.sv | 217 +++++++++++++++++++++
 tb/tb_sid_voice_mixer_tdm.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sid_mix_pkg.sv
// Shared definitions for the SID voice mixer.
//   - mix_state_t : scan sequencer state encoding
//   - acc_width   : accumulator width so that NUM_VOICES full-scale voices can never wrap
//   - scale_shift : right shift that brings voice*envelope back to OUT_W
//   - sat_to      : saturate a wide signed value to a signed width w
package sid_mix_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC   = 3'd1,
    S_DRAIN = 3'd2,
    S_MIX   = 3'd3,
    S_VOL   = 3'd4,
    S_DONE  = 3'd5
  } mix_state_t;

  localparam int VOL_W = 4;
  localparam int SAT_W = 64;

  function automatic int acc_width(input int out_w, input int n);
    return out_w + $clog2(n) + 1;
  endfunction

  function automatic int scale_shift(input int voice_w, input int env_w, input int out_w);
    return voice_w + env_w - out_w;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_to(input logic signed [SAT_W-1:0] x,
                                                      input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/sid_mac_lane.sv
// Registered signed x unsigned multiplier, one cycle of latency.
// Shared by the voice scan (voice * envelope) and the master-volume step
// (clip * volume). Shape matches a single DSP multiplier tile.
// Ports:
//   i_clk : clock
//   i_en  : product register enable
//   i_a   : signed multiplicand (two's complement)
//   i_b   : unsigned multiplier
//   o_p   : registered signed product, A_W+B_W+1 bits
module sid_mac_lane
  import sid_mix_pkg::*;
#(
  parameter int A_W = 16,
  parameter int B_W = 8
) (
  input  logic             i_clk,
  input  logic             i_en,
  input  logic [A_W-1:0]   i_a,
  input  logic [B_W-1:0]   i_b,
  output logic [A_W+B_W:0] o_p
);

  logic signed [A_W-1:0]   w_a;
  logic signed [B_W:0]     w_b;
  logic signed [A_W+B_W:0] r_p_p1;

  assign w_a = i_a;
  // Zero-extend so the unsigned operand stays positive in a signed multiply.
  assign w_b = {1'b0, i_b};

  // ---- stage p1: product register ----
  always_ff @(posedge i_clk) begin
    if (i_en) r_p_p1 <= w_a * w_b;
  end

  assign o_p = r_p_p1;

endmodule

// File: rtl/sid_voice_mixer_tdm.sv
// N-voice SID output stage built around one time-multiplexed multiply lane.
// On each sample strobe the voice/envelope/control inputs are snapshotted,
// every voice is scaled by its envelope and steered to the filter or bypass
// accumulator, the bypass sum is mixed with the enabled filter returns,
// clipped, and scaled by master volume.
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_start                : sample strobe; starts one scan when idle
//   i_voice / i_env        : packed per-voice oscillator (offset binary) and envelope
//   i_filt / i_mute        : per-voice filter routing and bypass mute
//   i_mode                 : [0] LP, [1] BP, [2] HP return enable
//   i_volume               : master volume 0..15
//   i_filt_lp/bp/hp        : signed filter returns, read live during MIX
//   o_pre_filter, o_output : registered signed filter input and final sample
//   o_valid                : one-cycle pulse when outputs update
//   o_busy                 : scan in progress
//   o_overrun              : sticky, strobe arrived while busy
module sid_voice_mixer_tdm
  import sid_mix_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int VOICE_W    = 12,
  parameter int ENV_W      = 8,
  parameter int OUT_W      = 16,
  parameter int HEADROOM   = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [NUM_VOICES*VOICE_W-1:0] i_voice,
  input  logic [NUM_VOICES*ENV_W-1:0]   i_env,
  input  logic [NUM_VOICES-1:0]         i_filt,
  input  logic [NUM_VOICES-1:0]         i_mute,
  input  logic [2:0]                    i_mode,
  input  logic [3:0]                    i_volume,
  input  logic [OUT_W-1:0]              i_filt_lp,
  input  logic [OUT_W-1:0]              i_filt_bp,
  input  logic [OUT_W-1:0]              i_filt_hp,
  output logic [OUT_W-1:0]              o_pre_filter,
  output logic [OUT_W-1:0]              o_output,
  output logic                          o_valid,
  output logic                          o_busy,
  output logic                          o_overrun
);

  localparam int ACC_W = acc_width(OUT_W, NUM_VOICES);
  localparam int SHIFT = scale_shift(VOICE_W, ENV_W, OUT_W);
  localparam int A_W   = (VOICE_W > OUT_W) ? VOICE_W : OUT_W;
  localparam int B_W   = (ENV_W > VOL_W) ? ENV_W : VOL_W;
  localparam int P_W   = A_W + B_W + 1;
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  mix_state_t r_state, w_next;

  logic [VOICE_W-1:0]    r_voice [NUM_VOICES];
  logic [ENV_W-1:0]      r_env   [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_filt, r_mute;
  logic [2:0]            r_mode;
  logic [3:0]            r_volume;
  logic [IDX_W-1:0]      r_idx;

  logic                     vld_p1, r_to_filt_p1, r_to_byp_p1;
  logic signed [ACC_W-1:0]  r_acc_filt, r_acc_byp;
  logic signed [OUT_W-1:0]  r_clip_p2, r_pre_p2;
  logic signed [OUT_W-1:0]  r_out, r_pre;
  logic                     r_valid, r_overrun;

  logic                     w_snap, w_issue;
  logic [A_W-1:0]           w_mul_a;
  logic [B_W-1:0]           w_mul_b;
  logic [P_W-1:0]           w_lane_p;
  logic signed [P_W-1:0]    w_prod;
  logic [VOICE_W-1:0]       w_cur;
  logic signed [VOICE_W-1:0] w_vs;
  logic signed [ACC_W-1:0]  w_amp;
  logic signed [OUT_W-1:0]  w_vol_out;
  logic signed [OUT_W-1:0]  w_byp_sat, w_filt_sat;
  logic signed [OUT_W-1:0]  w_lp, w_bp, w_hp;
  logic signed [OUT_W+1:0]  w_post;
  logic signed [OUT_W-1:0]  w_clip;

  // Offset binary -> two's complement: flip the MSB.
  assign w_cur = r_voice[r_idx];
  assign w_vs  = {~w_cur[VOICE_W-1], w_cur[VOICE_W-2:0]};

  sid_mac_lane #(
    .A_W (A_W),
    .B_W (B_W)
  ) u_lane (
    .i_clk (i_clk),
    .i_en  (1'b1),
    .i_a   (w_mul_a),
    .i_b   (w_mul_b),
    .o_p   (w_lane_p)
  );

  assign w_prod    = w_lane_p;
  // Magnitude of the scaled voice is below 2^(OUT_W-1-HEADROOM), so the
  // narrowing cast never drops significant bits.
  assign w_amp     = ACC_W'(w_prod >>> (SHIFT + HEADROOM));
  // |clip * volume / 16| < 2^(OUT_W-1): fits OUT_W; >>> floors toward -inf.
  assign w_vol_out = OUT_W'(w_prod >>> VOL_W);

  assign w_byp_sat  = OUT_W'(sat_to(SAT_W'(r_acc_byp), OUT_W));
  assign w_filt_sat = OUT_W'(sat_to(SAT_W'(r_acc_filt), OUT_W));
  assign w_lp       = r_mode[0] ? i_filt_lp : '0;
  assign w_bp       = r_mode[1] ? i_filt_bp : '0;
  assign w_hp       = r_mode[2] ? i_filt_hp : '0;
  // Four OUT_W terms cannot overflow OUT_W+2 bits.
  assign w_post     = (OUT_W+2)'(w_byp_sat) + (OUT_W+2)'(w_lp)
                    + (OUT_W+2)'(w_bp) + (OUT_W+2)'(w_hp);
  assign w_clip     = OUT_W'(sat_to(SAT_W'(w_post), OUT_W));

  // ---- state register ----
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // ---- next state ----
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_next = S_MAC;
      S_MAC:   if (r_idx == LAST_IDX) w_next = S_DRAIN;
      S_DRAIN: w_next = S_MIX;
      S_MIX:   w_next = S_VOL;
      S_VOL:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---- state outputs: lane operand select and enables ----
  always_comb begin
    w_snap  = 1'b0;
    w_issue = 1'b0;
    w_mul_a = '0;
    w_mul_b = '0;
    unique case (r_state)
      S_IDLE: w_snap = i_start;
      S_MAC: begin
        w_issue = 1'b1;
        w_mul_a = A_W'(w_vs);
        w_mul_b = B_W'(r_env[r_idx]);
      end
      S_VOL: begin
        w_mul_a = A_W'(r_clip_p2);
        w_mul_b = B_W'(r_volume);
      end
      default: ;
    endcase
  end

  // ---- snapshot and data pipeline (no reset needed) ----
  always_ff @(posedge i_clk) begin
    if (w_snap) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_voice[i] <= i_voice[i*VOICE_W +: VOICE_W];
        r_env[i]   <= i_env[i*ENV_W +: ENV_W];
      end
      r_filt   <= i_filt;
      r_mute   <= i_mute;
      r_mode   <= i_mode;
      r_volume <= i_volume;
    end
    // ---- stage p1: route flags travel with the lane product ----
    r_to_filt_p1 <= r_filt[r_idx];
    r_to_byp_p1  <= ~r_filt[r_idx] & ~r_mute[r_idx];
    // ---- stage p2: mix result held for the volume step ----
    if (r_state == S_MIX) begin
      r_clip_p2 <= w_clip;
      r_pre_p2  <= w_filt_sat;
    end
  end

  // ---- control, accumulators and output registers ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx      <= '0;
      vld_p1     <= 1'b0;
      r_acc_filt <= '0;
      r_acc_byp  <= '0;
      r_out      <= '0;
      r_pre      <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      vld_p1  <= w_issue;
      if (i_start && (r_state != S_IDLE)) r_overrun <= 1'b1;
      if (w_snap) begin
        r_idx      <= '0;
        r_acc_filt <= '0;
        r_acc_byp  <= '0;
      end
      if (r_state == S_MAC) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      if (vld_p1) begin
        if (r_to_filt_p1) r_acc_filt <= r_acc_filt + w_amp;
        if (r_to_byp_p1)  r_acc_byp  <= r_acc_byp + w_amp;
      end
      if (r_state == S_DONE) begin
        r_out   <= w_vol_out;
        r_pre   <= r_pre_p2;
        r_valid <= 1'b1;
      end
    end
  end

  assign o_output     = r_out;
  assign o_pre_filter = r_pre;
  assign o_valid      = r_valid;
  assign o_busy       = (r_state != S_IDLE);
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_sid_voice_mixer_tdm.sv
// Directed bench for sid_voice_mixer_tdm at default parameters (3 voices).
// Scaled voice for v=12'hFFF, env=255: 2047*255=521985; >>>4 -> 32624; >>>3 -> 4078.
// Scaled voice for v=12'h000, env=255: -2048*255=-522240; >>>4 -> -32640; >>>3 -> -4080.
module tb_sid_voice_mixer_tdm;

  logic        clk = 1'b0;
  logic        i_rst, i_start;
  logic [35:0] i_voice;
  logic [23:0] i_env;
  logic [2:0]  i_filt, i_mute, i_mode;
  logic [3:0]  i_volume;
  logic [15:0] i_filt_lp, i_filt_bp, i_filt_hp;
  logic [15:0] o_pre_filter, o_output;
  logic        o_valid, o_busy, o_overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int lat, pulses;
  logic signed [63:0] out_at, pre_at;

  always #5 clk = ~clk;

  sid_voice_mixer_tdm dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_voice      (i_voice),
    .i_env        (i_env),
    .i_filt       (i_filt),
    .i_mute       (i_mute),
    .i_mode       (i_mode),
    .i_volume     (i_volume),
    .i_filt_lp    (i_filt_lp),
    .i_filt_bp    (i_filt_bp),
    .i_filt_hp    (i_filt_hp),
    .o_pre_filter (o_pre_filter),
    .o_output     (o_output),
    .o_valid      (o_valid),
    .o_busy       (o_busy),
    .o_overrun    (o_overrun)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Strobe sampled at the rising edge between the two falling edges; returns half a cycle after.
  task automatic pulse_start();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
  endtask

  // Bounded watch of VALID; lat = falling edge index of the first pulse, -1 if none.
  task automatic wait_valid(input int limit, output int l, output int np,
                            output logic signed [63:0] o_at, output logic signed [63:0] p_at);
    l = -1; np = 0; o_at = 'x; p_at = 'x;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (o_valid) begin
        np++;
        if (l < 0) begin
          l = k; o_at = $signed(o_output); p_at = $signed(o_pre_filter);
        end
      end
    end
  endtask

  task automatic stim_bypass();
    i_voice = {12'h800, 12'h800, 12'hFFF};
    i_env   = {8'd255, 8'd255, 8'd255};
    i_filt = 3'b000; i_mute = 3'b000; i_mode = 3'b000; i_volume = 4'd15;
    i_filt_lp = '0; i_filt_bp = '0; i_filt_hp = '0;
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b1;
    stim_bypass();

    // 1. Reset, with START held to show reset wins.
    repeat (3) @(negedge clk);
    check("rst_output",  $signed(o_output), 0);
    check("rst_pre",     $signed(o_pre_filter), 0);
    check("rst_valid",   o_valid, 0);
    check("rst_busy",    o_busy, 0);
    check("rst_overrun", o_overrun, 0);
    i_rst = 1'b0; i_start = 1'b0;
    @(negedge clk);
    check("rst_wins_busy", o_busy, 0);

    // 2. Bypass: post=4078, 4078*15=61170 >>4 = 3823.
    pulse_start();
    check("t2_busy", o_busy, 1);
    wait_valid(20, lat, pulses, out_at, pre_at);
    check("t2_latency", lat, 7);
    check("t2_pulses",  pulses, 1);
    check("t2_output",  out_at, 3823);
    check("t2_pre",     pre_at, 0);
    check("t2_idle_busy", o_busy, 0);
    check("t2_overrun", o_overrun, 0);

    // 3. Voice0 to filter, LP return 1000: pre=4078, 1000*15=15000>>4=937.
    //    Voice and volume change right after the strobe; the snapshot must hold.
    i_filt = 3'b001; i_mode = 3'b001; i_filt_lp = 16'd1000;
    pulse_start();
    i_voice = {12'h800, 12'h800, 12'h800}; i_volume = 4'd0; i_filt = 3'b000;
    wait_valid(20, lat, pulses, out_at, pre_at);
    check("t3_pre",    pre_at, 4078);
    check("t3_output", out_at, 937);

    // 4. Saturation: bypass -12240, HP -32768 -> post clips to -32768; *15>>4 = -30720.
    stim_bypass();
    i_voice = {12'h000, 12'h000, 12'h000}; i_mode = 3'b100; i_filt_hp = 16'h8000;
    pulse_start();
    wait_valid(20, lat, pulses, out_at, pre_at);
    check("t4_output", out_at, -30720);
    check("t4_pre",    pre_at, 0);

    // Floor on negative values: BP -1000 alone, -15000>>4 = -937.5 -> -938.
    stim_bypass();
    i_voice = {12'h800, 12'h800, 12'h800}; i_mode = 3'b010; i_filt_bp = -16'sd1000;
    pulse_start();
    wait_valid(20, lat, pulses, out_at, pre_at);
    check("floor_output", out_at, -938);

    // Volume 0 silences a full-scale bypass voice.
    stim_bypass(); i_volume = 4'd0;
    pulse_start();
    wait_valid(20, lat, pulses, out_at, pre_at);
    check("vol0_output", out_at, 0);

    // 5. Second strobe at T+2 is ignored; one pulse, four edges later; OVERRUN sticks.
    stim_bypass();
    pulse_start();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    wait_valid(20, lat, pulses, out_at, pre_at);
    check("t5_latency", lat, 5);
    check("t5_pulses",  pulses, 1);
    check("t5_output",  out_at, 3823);
    check("t5_overrun", o_overrun, 1);

    // 6a. Mute voice0: removed from bypass, nothing in the filter path.
    i_mute = 3'b001;
    pulse_start();
    wait_valid(20, lat, pulses, out_at, pre_at);
    check("t6_mute_output", out_at, 0);
    check("t6_mute_pre",    pre_at, 0);

    // Load nonzero outputs (test-3 stimulus) so the abort is observable.
    i_mute = 3'b000; i_filt = 3'b001; i_mode = 3'b001; i_filt_lp = 16'd1000;
    pulse_start();
    wait_valid(20, lat, pulses, out_at, pre_at);
    check("t6_load_pre", pre_at, 4078);
    check("t6_overrun_sticky", o_overrun, 1);

    // 6b. Reset sampled at T+3 aborts the scan.
    pulse_start();
    @(negedge clk);
    @(negedge clk); i_rst = 1'b1;
    @(negedge clk); i_rst = 1'b0;
    check("t6_abort_output",  $signed(o_output), 0);
    check("t6_abort_pre",     $signed(o_pre_filter), 0);
    check("t6_abort_busy",    o_busy, 0);
    check("t6_abort_overrun", o_overrun, 0);
    wait_valid(20, lat, pulses, out_at, pre_at);
    check("t6_abort_pulses", pulses, 0);

    // Next strobe completes normally.
    stim_bypass();
    pulse_start();
    wait_valid(20, lat, pulses, out_at, pre_at);
    check("t6_after_latency", lat, 7);
    check("t6_after_output",  out_at, 3823);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
